// File: rtl/sti_serializer_p_if.sv
// Load/ready request and serial-output bundle for sti_serializer_p.
// master drives the request; slave is the serializer.
interface sti_serializer_p_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BYTES = 4
);
    localparam int unsigned LEN_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned CNT_W = $clog2(8 * MAX_BYTES + 1);

    logic              load;
    logic [DATA_W-1:0] pi_data;
    logic [LEN_W-1:0]  pi_length;
    logic              pi_fill;
    logic              pi_low;
    logic              pi_msb;
    logic              ready;
    logic              so_data;
    logic              so_valid;
    logic              done;
    logic [CNT_W-1:0]  out_bit;

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_low, pi_msb,
        input  ready, so_data, so_valid, done, out_bit
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_low, pi_msb,
        output ready, so_data, so_valid, done, out_bit
    );
endinterface

// File: rtl/sti_serializer_p.sv
// Parametrised parallel-in/serial-out transmitter with load/ready handshake and done strobe.
// Define STI_PARITY_EN to append an even-parity bit after each frame.
module sti_serializer_p #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BYTES = 4
) (
    input  logic             clk,
    input  logic             reset,
    sti_serializer_p_if.slave bus
);
    localparam int unsigned LEN_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned CNT_W   = $clog2(8 * MAX_BYTES + 1);
    localparam int unsigned FRAME_W = 8 * MAX_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_BITS  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {StIdle, StShift, StParity, StDone} state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   fbits_q, fbits_d;
    logic               msb_q, msb_d;
`ifdef STI_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [LEN_W-1:0]   len_clamp;
    logic [CNT_W-1:0]   f_new;
    logic [FRAME_W-1:0] data_ext, frame_mask, frame_new;

    always_comb begin
        len_clamp  = (bus.pi_length > MAX_LEN) ? MAX_LEN : bus.pi_length;
        f_new      = CNT_W'({len_clamp, 3'b000}) + CNT_W'(8);
        data_ext   = FRAME_W'(bus.pi_data);
        frame_mask = ~({FRAME_W{1'b1}} << f_new);
        if (f_new < DATA_BITS) begin
            frame_new = (bus.pi_low ? (data_ext >> (DATA_BITS - f_new)) : data_ext) & frame_mask;
        end else if ((f_new > DATA_BITS) && bus.pi_fill) begin
            frame_new = data_ext << (f_new - DATA_BITS);
        end else begin
            frame_new = data_ext;
        end
        // MSB-first frames are left-aligned so the next bit is always the register's top bit
        if (bus.pi_msb) begin
            frame_new = frame_new << (FRAME_BITS - f_new);
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        cnt_d        = cnt_q;
        fbits_d      = fbits_q;
        msb_d        = msb_q;
`ifdef STI_PARITY_EN
        parity_d     = parity_q;
`endif
        bus.ready    = 1'b0;
        bus.so_data  = 1'b0;
        bus.so_valid = 1'b0;
        bus.done     = 1'b0;
        bus.out_bit  = fbits_q;

        unique case (state_q)
            StIdle: begin
                bus.ready = 1'b1;
                if (bus.load) begin
                    state_d  = StShift;
                    frame_d  = frame_new;
                    cnt_d    = '0;
                    fbits_d  = f_new;
                    msb_d    = bus.pi_msb;
`ifdef STI_PARITY_EN
                    parity_d = ^frame_new;
`endif
                end
            end
            StShift: begin
                bus.so_valid = 1'b1;
                bus.so_data  = msb_q ? frame_q[FRAME_W-1] : frame_q[0];
                frame_d      = msb_q ? (frame_q << 1) : (frame_q >> 1);
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == fbits_q - CNT_W'(1)) begin
                    cnt_d = '0;
`ifdef STI_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef STI_PARITY_EN
            StParity: begin
                bus.so_valid = 1'b1;
                bus.so_data  = parity_q;
                state_d      = StDone;
            end
`endif
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
                fbits_d  = '0;
                frame_d  = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            frame_q  <= '0;
            cnt_q    <= '0;
            fbits_q  <= '0;
            msb_q    <= 1'b0;
`ifdef STI_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            fbits_q  <= fbits_d;
            msb_q    <= msb_d;
`ifdef STI_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_sti_serializer_p.sv
// Randomised scoreboard bench for sti_serializer_p (DATA_W=16, MAX_BYTES=4).
// Expected serial bits are queued at load time; a negedge monitor pops and compares.
module tb_sti_serializer_p;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MAX_BYTES = 4;

    typedef struct {
        bit b;
        int f;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sti_serializer_p_if #(.DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES)) bus ();

    sti_serializer_p #(.DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   pending_done = 1'b0;
    bit   prev_done = 1'b0;
    bit   mid_frame = 1'b0;

    function automatic void check(string name, longint unsigned act, longint unsigned req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endfunction

    // Reference: frame value from the placement rules, then bits in transmit order.
    function automatic void push_frame(logic [DATA_W-1:0] d, int len, bit fill, bit low,
                                       bit msb);
        int f;
        longint unsigned dv;
        longint unsigned fr;
        bit par;
        exp_t e;
        f   = 8 * (len + 1);
        dv  = 64'(d);
        par = 1'b0;
        if (f < int'(DATA_W)) fr = low ? (dv >> (int'(DATA_W) - f)) : (dv & ((64'd1 << f) - 1));
        else if (f > int'(DATA_W) && fill) fr = dv << (f - int'(DATA_W));
        else fr = dv;
        for (int k = 0; k < f; k++) begin
            e.b    = msb ? fr[f-1-k] : fr[k];
            e.f    = f;
`ifdef STI_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (k == f - 1);
`endif
            par    = par ^ e.b;
            exp_q.push_back(e);
        end
`ifdef STI_PARITY_EN
        e.b    = par;
        e.f    = f;
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (pending_done || bus.done) begin
                check("done", bus.done, pending_done);
                if (pending_done) check("ready_in_done", bus.ready, 0);
            end
            if (prev_done) check("ready_after_done", bus.ready, 1);
            if (bus.ready) check("idle_out_bit", bus.out_bit, 0);
            prev_done    = bus.done;
            pending_done = 1'b0;
            if (bus.so_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", bus.so_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("so_data", bus.so_data, e.b);
                    check("out_bit", bus.out_bit, e.f);
                    if (e.last) begin
                        pending_done = 1'b1;
                        mid_frame    = 1'b0;
                    end else begin
                        mid_frame = 1'b1;
                    end
                end
            end else begin
                if (mid_frame) begin
                    check("gap_valid", bus.so_valid, 1);
                    mid_frame = 1'b0;
                end
                check("idle_so_data", bus.so_data, 0);
            end
        end
    end

    task automatic scramble();
        bus.pi_data   = DATA_W'($urandom);
        bus.pi_length = 2'($urandom);
        bus.pi_fill   = 1'($urandom);
        bus.pi_low    = 1'($urandom);
        bus.pi_msb    = 1'($urandom);
    endtask

    task automatic send(logic [DATA_W-1:0] d, int len, bit fill, bit low, bit msb, bit glitch);
        int w = 0;
        while (!bus.ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.ready) begin
            check("ready_wait", bus.ready, 1);
            return;
        end
        bus.pi_data   = d;
        bus.pi_length = 2'(len);
        bus.pi_fill   = fill;
        bus.pi_low    = low;
        bus.pi_msb    = msb;
        bus.load      = 1'b1;
        push_frame(d, len, fill, low, msb);
        @(posedge clk); #1;
        bus.load = 1'b0;
        scramble();
        if (glitch) begin
            @(posedge clk); #1;
            check("busy_ready", bus.ready, 0);
            bus.load = 1'b1;
            scramble();
            @(posedge clk); #1;
            bus.load = 1'b0;
        end
    endtask

    initial begin
        int w;
        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.pi_data   = '0;
        bus.pi_length = '0;
        bus.pi_fill   = 1'b0;
        bus.pi_low    = 1'b0;
        bus.pi_msb    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", bus.ready, 1);
        check("rst_so_valid", bus.so_valid, 0);
        check("rst_so_data", bus.so_data, 0);
        check("rst_done", bus.done, 0);
        check("rst_out_bit", bus.out_bit, 0);

        send(16'hA5C3, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(16'hA5C3, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'hFFFF, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h1234, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        send(16'h0007, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // load held during the done cycle must not start a frame
        w = 0;
        while (!bus.done && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("done_seen", bus.done, 1);
        bus.load = 1'b1;
        scramble();
        @(posedge clk); #1;
        bus.load = 1'b0;

        // reset in the middle of a frame
        send(16'hBEEF, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        mid_frame    = 1'b0;
        pending_done = 1'b0;
        prev_done    = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_so_valid", bus.so_valid, 0);
        check("midrst_ready", bus.ready, 1);
        check("midrst_out_bit", bus.out_bit, 0);
        check("midrst_done", bus.done, 0);

        for (int i = 0; i < 40; i++) begin
            send(DATA_W'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        w = 0;
        while ((exp_q.size() != 0 || pending_done || !bus.ready) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
